// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for the register file: two read ports, one writeback port, one issue port.
// master = pipeline side driving addresses, writes and issues; slave = the register file.
interface regfile_scoreboard_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] reg_address1;
  logic [ADDR_WIDTH-1:0] reg_address2;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;
  logic                  busy1;
  logic                  busy2;
  logic                  write;
  logic [ADDR_WIDTH-1:0] reg_write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] issue_address;
  logic [ADDR_WIDTH:0]   pending_count;

  modport master (
    output reg_address1, reg_address2, write, reg_write_address, write_data,
           issue, issue_address,
    input  read_data1, read_data2, busy1, busy2, pending_count
  );

  modport slave (
    input  reg_address1, reg_address2, write, reg_write_address, write_data,
           issue, issue_address,
    output read_data1, read_data2, busy1, busy2, pending_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with write-through bypass plus a per-register pending (RAW hazard) scoreboard.
// Reads/busy are combinational; writes, issues and pending_count update on the edge; no backpressure, busy is the stall hint.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  rf
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      pending_q, pending_d;
  logic [CW-1:0]         pending_count_q, pending_count_d;

  logic wr_en, iss_en, cnt_inc, cnt_dec;

  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] a);
    if (is_zero_reg(a))
      return '0;
    else if (rf.write && (rf.reg_write_address == a))
      return rf.write_data;
    else
      return regs_q[a];
  endfunction

  // A same-cycle write to the read address resolves the hazard; a same-cycle issue does not.
  function automatic logic busy_port(input logic [ADDR_WIDTH-1:0] a);
    return !is_zero_reg(a) && pending_q[a] &&
           !(rf.write && (rf.reg_write_address == a));
  endfunction

  always_comb begin
    wr_en  = rf.write && !is_zero_reg(rf.reg_write_address);
    iss_en = rf.issue && !is_zero_reg(rf.issue_address);

    regs_d    = regs_q;
    pending_d = pending_q;
    if (wr_en) begin
      regs_d[rf.reg_write_address]    = rf.write_data;
      pending_d[rf.reg_write_address] = 1'b0;
    end
    // Issue is applied after the write so a same-address pair leaves the bit set.
    if (iss_en)
      pending_d[rf.issue_address] = 1'b1;

    cnt_inc = iss_en && !pending_q[rf.issue_address];
    cnt_dec = wr_en && pending_q[rf.reg_write_address] &&
              !(iss_en && (rf.issue_address == rf.reg_write_address));
    pending_count_d = pending_count_q + CW'(cnt_inc) - CW'(cnt_dec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q          <= '{default: '0};
      pending_q       <= '0;
      pending_count_q <= '0;
    end else begin
      regs_q          <= regs_d;
      pending_q       <= pending_d;
      pending_count_q <= pending_count_d;
    end
  end

  assign rf.read_data1    = read_port(rf.reg_address1);
  assign rf.read_data2    = read_port(rf.reg_address2);
  assign rf.busy1         = busy_port(rf.reg_address1);
  assign rf.busy2         = busy_port(rf.reg_address2);
  assign rf.pending_count = pending_count_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized plus directed bench for regfile_scoreboard against an array-based model of register/pending state.
module tb_regfile_scoreboard;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf ();

  regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
    .clk  (clk),
    .reset(reset),
    .rf   (rf)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];

  // Model state advance: registers and pending bits as plain arrays.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (rf.write && rf.reg_write_address != 0) begin
        m_regs[rf.reg_write_address] = rf.write_data;
        m_pend[rf.reg_write_address] = 1'b0;
      end
      if (rf.issue && rf.issue_address != 0)
        m_pend[rf.issue_address] = 1'b1;
    end
  end

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (rf.write && rf.reg_write_address == a) return rf.write_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return (a != 0) && m_pend[a] && !(rf.write && rf.reg_write_address == a);
  endfunction

  function automatic int exp_count();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd1",   rf.read_data1, exp_read(rf.reg_address1));
      check("rd2",   rf.read_data2, exp_read(rf.reg_address2));
      check("busy1", DW'(rf.busy1), DW'(exp_busy(rf.reg_address1)));
      check("busy2", DW'(rf.busy2), DW'(exp_busy(rf.reg_address2)));
      check("count", DW'(rf.pending_count), DW'(exp_count()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    rf.write = 1'b0;
    rf.issue = 1'b0;
  endtask

  task automatic randomize_inputs(input int wr_pct, input int is_pct);
    rf.reg_address1      = AW'($urandom_range(NR - 1));
    rf.reg_address2      = AW'($urandom_range(NR - 1));
    rf.write             = ($urandom_range(99) < wr_pct);
    rf.reg_write_address = AW'($urandom_range(NR - 1));
    rf.write_data        = $urandom;
    rf.issue             = ($urandom_range(99) < is_pct);
    rf.issue_address     = AW'($urandom_range(NR - 1));
  endtask

  initial begin
    reset = 1'b1;
    rf.reg_address1 = '0; rf.reg_address2 = '0;
    rf.reg_write_address = '0; rf.write_data = '0;
    rf.issue_address = '0;
    idle();
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;

    // Random writes/issues, then a single-cycle reset.
    for (int i = 0; i < 12; i++) begin
      randomize_inputs(80, 50);
      tick();
    end
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rf.reg_address1 = 5'd5;
    rf.reg_address2 = 5'd9;
    at_neg();
    check("rst_rd1",   rf.read_data1, 32'h0);
    check("rst_rd2",   rf.read_data2, 32'h0);
    check("rst_busy1", DW'(rf.busy1), 32'h0);
    check("rst_cnt",   DW'(rf.pending_count), 32'h0);
    tick();

    // Write-through bypass then storage.
    rf.write = 1'b1; rf.reg_write_address = 5'd5; rf.write_data = 32'hDEADBEEF;
    rf.reg_address1 = 5'd5;
    at_neg();
    check("bypass_rd1", rf.read_data1, 32'hDEADBEEF);
    tick();
    idle();
    at_neg();
    check("stored_rd1", rf.read_data1, 32'hDEADBEEF);
    tick();

    // Zero register ignores write and issue.
    rf.write = 1'b1; rf.reg_write_address = 5'd0; rf.write_data = 32'h12345678;
    rf.issue = 1'b1; rf.issue_address = 5'd0;
    rf.reg_address1 = 5'd0;
    at_neg();
    check("zero_rd1_same", rf.read_data1, 32'h0);
    tick();
    idle();
    at_neg();
    check("zero_rd1",   rf.read_data1, 32'h0);
    check("zero_busy1", DW'(rf.busy1), 32'h0);
    check("zero_cnt",   DW'(rf.pending_count), 32'h0);
    tick();

    // Scoreboard lifecycle on r7.
    rf.issue = 1'b1; rf.issue_address = 5'd7;
    rf.reg_address2 = 5'd7;
    tick();
    idle();
    for (int c = 1; c <= 3; c++) begin
      at_neg();
      check("sb_busy2", DW'(rf.busy2), 32'h1);
      check("sb_cnt",   DW'(rf.pending_count), 32'h1);
      tick();
    end
    rf.write = 1'b1; rf.reg_write_address = 5'd7; rf.write_data = 32'hA5;
    at_neg();
    check("sb_wr_busy2", DW'(rf.busy2), 32'h0);
    check("sb_wr_rd2",   rf.read_data2, 32'hA5);
    tick();
    idle();
    at_neg();
    check("sb_cnt_clr", DW'(rf.pending_count), 32'h0);
    tick();

    // Simultaneous issue and write to pending r9.
    rf.issue = 1'b1; rf.issue_address = 5'd9;
    rf.reg_address1 = 5'd9;
    tick();
    rf.write = 1'b1; rf.reg_write_address = 5'd9; rf.write_data = 32'h0000_0099;
    at_neg();
    check("r9_busy_same", DW'(rf.busy1), 32'h0);
    check("r9_cnt_pre",   DW'(rf.pending_count), 32'h1);
    tick();
    idle();
    at_neg();
    check("r9_busy_next", DW'(rf.busy1), 32'h1);
    check("r9_rd1",       rf.read_data1, 32'h0000_0099);
    check("r9_cnt",       DW'(rf.pending_count), 32'h1);
    tick();
    rf.write = 1'b1; rf.reg_write_address = 5'd9; rf.write_data = 32'h1;
    tick();
    idle();

    // Count saturation and drain.
    for (int r = 1; r < NR; r++) begin
      rf.issue = 1'b1; rf.issue_address = AW'(r);
      tick();
    end
    rf.issue = 1'b1; rf.issue_address = 5'd3;
    at_neg();
    check("sat_cnt_31", DW'(rf.pending_count), 32'd31);
    tick();
    idle();
    at_neg();
    check("sat_cnt_reissue", DW'(rf.pending_count), 32'd31);
    tick();
    for (int r = 1; r < NR; r++) begin
      rf.write = 1'b1; rf.reg_write_address = AW'(r); rf.write_data = $urandom;
      tick();
    end
    idle();
    at_neg();
    check("drain_cnt", DW'(rf.pending_count), 32'd0);
    tick();

    // Random soak with occasional mid-operation resets.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs(45, 45);
      reset = ($urandom_range(99) == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-read register file with an integrated hazard scoreboard for the pipelined MIPS datapath. It holds the architectural registers and forwards same-cycle writes to the read ports. It also tracks which registers have an in-flight producer so the decode stage can stall on read-after-write hazards. It sits between decode (read and issue) and writeback (write).

## Interface

- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes and issues.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all registers, all pending bits and pending_count.
- reg_address1  input  ADDR_WIDTH  read port 1 index.
- reg_address2  input  ADDR_WIDTH  read port 2 index.
- read_data1  output  DATA_WIDTH  combinational read port 1 data.
- read_data2  output  DATA_WIDTH  combinational read port 2 data.
- busy1  output  1  combinational; port 1 register has an unresolved producer.
- busy2  output  1  combinational; port 2 register has an unresolved producer.
- write  input  1  writeback enable.
- reg_write_address  input  ADDR_WIDTH  writeback index.
- write_data  input  DATA_WIDTH  writeback data.
- issue  input  1  decode issued an instruction that will write issue_address.
- issue_address  input  ADDR_WIDTH  destination index of the issued instruction.
- pending_count  output  ADDR_WIDTH+1  number of registers currently marked pending.

## Operation

- **Storage:** 2**ADDR_WIDTH x DATA_WIDTH registers plus one pending bit per register.
- **Write:** if write is high on a rising edge, registers[reg_write_address] <= write_data and pending[reg_write_address] <= 0.
  - Exception: when ZERO_REG=1 and the address is 0, nothing is written.
- **Issue:** if issue is high on a rising edge, pending[issue_address] <= 1.
  - Ignored when ZERO_REG=1 and the address is 0.
- **Issue and write to the same address in the same cycle:**
  - The write data is stored.
  - The pending bit ends at 1, because the issue names a newer producer.
- **Read (per port n):**
  - Returns 0 if ZERO_REG=1 and the address is 0.
  - Otherwise returns write_data if write is high and reg_write_address equals the read address (write-through bypass).
  - Otherwise returns the stored register.
- **busyN:** pending[addrN] AND NOT (write AND reg_write_address == addrN).
  - A same-cycle write resolves the hazard.
  - A same-cycle issue does not affect busyN.
  - busyN is always 0 for address 0 when ZERO_REG=1.
- **pending_count:** population count of the pending bits, maintained as a registered counter.
  - Net change per cycle is +1, -1 or 0.
  - +1 only if the issue sets a bit that was 0.
  - -1 only if the write clears a bit that was 1 and no same-address issue occurs.
  - Issue and write to different addresses: both effects apply.
  - Issue to an already-pending address: no change; the bit stays 1.
  - Write to a non-pending address: no change.
- **Reset:** takes priority over write and issue in the same cycle. After the reset edge:
  - all registers are 0;
  - all pending bits are 0;
  - pending_count is 0;
  - read_data1/2 are 0 and busy1/2 are 0, absent a same-cycle bypassing write.

## Timing

- Read data, the bypass and busy are zero-latency combinational paths from the address, write and write-index inputs.
- A write is visible through the bypass in its own cycle and from storage starting the next cycle.
- An issue affects busy and pending_count starting the cycle after the issuing edge.
- A write clears the pending bit at its edge; pending_count updates at the same edge.
- pending_count never exceeds 2**ADDR_WIDTH - ZERO_REG and never underflows.
- A reset asserted mid-operation discards in-flight pending state; later writes to those registers behave as plain writes.

## Test plan

- **Reset:** assert reset for 1 cycle after random writes.
  - Expect all reads 0, busy1/2 0, pending_count 0.
- **Write then read:** write 0xDEADBEEF to r5, with reg_address1=5 in the same cycle.
  - Same cycle: read_data1=0xDEADBEEF (bypass).
  - Next cycle with write low: read_data1 still 0xDEADBEEF.
- **Zero register:** write 0x12345678 to r0 and issue r0.
  - Expect read_data1=0, busy1=0, pending_count unchanged at 0.
- **Scoreboard:** issue r7 at cycle 0.
  - Cycles 1-3 with reg_address2=7: busy2=1, pending_count=1.
  - Cycle 4: write r7=0xA5 gives busy2=0 and read_data2=0xA5 in the same cycle; pending_count=0 at cycle 5.
- **Simultaneous issue and write to r9 (r9 pending):**
  - r9 stores the data; the pending bit remains 1.
  - busy on r9 next cycle is 1; pending_count is unchanged.
- **Count saturation:** issue r1..r31 on consecutive cycles, then re-issue r3.
  - Expect pending_count=31 with no increment on the re-issue.
  - Writing r1..r31 back then brings the count to 0.
